// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: segment bit positions,
// the active-high hex glyph table and the all-off pattern.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] MA = 7'(1 << SEG_A);
    localparam logic [6:0] MB = 7'(1 << SEG_B);
    localparam logic [6:0] MC = 7'(1 << SEG_C);
    localparam logic [6:0] MD = 7'(1 << SEG_D);
    localparam logic [6:0] ME = 7'(1 << SEG_E);
    localparam logic [6:0] MF = 7'(1 << SEG_F);
    localparam logic [6:0] MG = 7'(1 << SEG_G);

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Glyphs 0-F; b and d are lower case so they differ from 8 and 0.
    localparam logic [6:0] HEX_TABLE [16] = '{
        MA | MB | MC | MD | ME | MF,
        MB | MC,
        MA | MB | MD | ME | MG,
        MA | MB | MC | MD | MG,
        MB | MC | MF | MG,
        MA | MC | MD | MF | MG,
        MA | MC | MD | ME | MF | MG,
        MA | MB | MC,
        MA | MB | MC | MD | ME | MF | MG,
        MA | MB | MC | MD | MF | MG,
        MA | MB | MC | ME | MF | MG,
        MC | MD | ME | MF | MG,
        MA | MD | ME | MF,
        MB | MC | MD | ME | MG,
        MA | MD | ME | MF | MG,
        MA | ME | MF | MG
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pat
);

    assign pat = HEX_TABLE[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered digits, frame-aligned
// commits, leading-zero blanking and an anode-off guard at each slot start.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                      CLK100MHZ,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      load,
    input  logic                      blank_lz,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic [6:0]                seg,
    output logic                      DP,
    output logic                      frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic            POL       = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   GUARD_END = CW'(GUARD);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             cnt_p0;
    logic [IW-1:0]             idx_p0;
    logic [4*NUM_DIGITS-1:0]   pend_val, disp_val;
    logic [NUM_DIGITS-1:0]     pend_dp, pend_en, disp_dp, disp_en;
    logic                      pend_vld, blz_q;
    logic                      tick, wrap;
    logic [3:0]                cur_nib;
    logic [6:0]                glyph, seg_h;
    logic [NUM_DIGITS-1:0]     an_h;

    // Digit i>0 is a leading zero when it and every digit above it is zero or disabled.
    function automatic logic lz_blank(input logic [4*NUM_DIGITS-1:0] v,
                                      input logic [NUM_DIGITS-1:0]   en,
                                      input logic [IW-1:0]           i);
        logic zero_above;
        zero_above = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(i) && en[j] && v[4*j +: 4] != 4'h0) zero_above = 1'b0;
        end
        return (i != '0) && zero_above;
    endfunction

    assign tick = (cnt_p0 == CNT_LAST);
    assign wrap = tick && (idx_p0 == IDX_LAST);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            cnt_p0   <= '0;
            idx_p0   <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend_en  <= '0;
            pend_vld <= 1'b0;
            disp_val <= '0;
            disp_dp  <= '0;
            disp_en  <= '0;
            blz_q    <= 1'b0;
        end else begin
            cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
            if (tick) idx_p0 <= wrap ? '0 : idx_p0 + 1'b1;
            // A load landing on the commit tick bypasses the pending buffer.
            if (wrap && load) begin
                disp_val <= value;
                disp_dp  <= dp;
                disp_en  <= digit_en;
                pend_vld <= 1'b0;
                blz_q    <= blank_lz;
            end else if (wrap && pend_vld) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                disp_en  <= pend_en;
                pend_vld <= 1'b0;
                blz_q    <= blank_lz;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
                pend_en  <= digit_en;
                pend_vld <= 1'b1;
            end
        end
    end

    assign cur_nib = disp_val[4*idx_p0 +: 4];

    hex_to_seg7 u_dec (
        .nib (cur_nib),
        .pat (glyph)
    );

    // Disabled digits keep their segments dark as well as their anode.
    always_comb begin
        an_h = '0;
        if (cnt_p0 >= GUARD_END && disp_en[idx_p0]) an_h[idx_p0] = 1'b1;
        seg_h = glyph;
        if (!disp_en[idx_p0] || (blz_q && lz_blank(disp_val, disp_en, idx_p0)))
            seg_h = SEG_OFF;
    end

    // Output stage: registered, polarity applied once here.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            AN         <= {NUM_DIGITS{POL}};
            seg        <= SEG_OFF ^ {7{POL}};
            DP         <= POL;
            frame_done <= 1'b0;
        end else begin
            AN         <= an_h ^ {NUM_DIGITS{POL}};
            seg        <= seg_h ^ {7{POL}};
            DP         <= disp_dp[idx_p0] ^ POL;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle guard, active-low).
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int G     = 2;
    localparam int FRAME = ND * RD;

    // Active-low glyphs 0-F.
    localparam logic [6:0] GLYPH_AL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    digit_en = '0;
    logic          load = 1'b0;
    logic          blank_lz = 1'b0;
    logic [3:0]    AN;
    logic [6:0]    seg;
    logic          DP;
    logic          frame_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset plus the two buffers.
    int          n = 0;
    logic [15:0] d_val = '0, p_val = '0;
    logic [3:0]  d_dp = '0, d_en = '0, p_dp = '0, p_en = '0;
    logic        pv = 1'b0, blz = 1'b0;
    exp_t        q[$];

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD       (G),
        .ACTIVE_LOW  (1)
    ) dut (
        .CLK100MHZ  (clk),
        .reset      (rst),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .load       (load),
        .blank_lz   (blank_lz),
        .AN         (AN),
        .seg        (seg),
        .DP         (DP),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    function automatic exp_t expect_now();
        exp_t e;
        int   cnt, idx;
        bit   lz;
        cnt = n % RD;
        idx = (n / RD) % ND;
        e.an = 4'hF;
        if (cnt >= G && d_en[idx]) e.an[idx] = 1'b0;
        lz = (idx > 0);
        for (int j = 0; j < ND; j++)
            if (j >= idx && d_en[j] && d_val[4*j +: 4] != 4'h0) lz = 0;
        if (!d_en[idx] || (blz && lz)) e.seg = 7'h7F;
        else e.seg = GLYPH_AL[d_val[4*idx +: 4]];
        e.dp = ~d_dp[idx];
        e.fd = (n % FRAME == FRAME - 1);
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0;
            d_val <= '0; d_dp <= '0; d_en <= '0;
            p_val <= '0; p_dp <= '0; p_en <= '0;
            pv <= 1'b0; blz <= 1'b0;
            q.delete();
        end else begin
            q.push_back(expect_now());
            if ((n % FRAME == FRAME - 1) && load) begin
                d_val <= value; d_dp <= dp; d_en <= digit_en;
                pv <= 1'b0; blz <= blank_lz;
            end else if ((n % FRAME == FRAME - 1) && pv) begin
                d_val <= p_val; d_dp <= p_dp; d_en <= p_en;
                pv <= 1'b0; blz <= blank_lz;
            end else if (load) begin
                p_val <= value; p_dp <= dp; p_en <= digit_en;
                pv <= 1'b1;
            end
            n <= n + 1;
        end
    end

    task automatic check(input string name, input exp_t act, input exp_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t: got AN=%b seg=%b DP=%b fd=%b, want AN=%b seg=%b DP=%b fd=%b",
                     name, $time, act.an, act.seg, act.dp, act.fd,
                     req.an, req.seg, req.dp, req.fd);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("scan", {AN, seg, DP, frame_done}, e);
        end
    end

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e, input logic b);
        value = v; dp = d; digit_en = e; blank_lz = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int r);
        int k;
        k = 0;
        while ((n % FRAME) != r && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase: phase %0d not reached, at %0d", r, n % FRAME);
        end
    endtask

    localparam exp_t INACTIVE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

    initial begin
        logic [15:0] rv;
        idle(3);
        check("reset_state", {AN, seg, DP, frame_done}, INACTIVE);
        rst = 1'b0;
        idle(40);

        do_load(16'h1A30, 4'h0, 4'hF, 1'b0);
        idle(40);

        wait_phase(5);
        do_load(16'h1111, 4'h0, 4'hF, 1'b0);
        idle(5);
        do_load(16'h2222, 4'h0, 4'hF, 1'b0);
        idle(40);

        wait_phase(FRAME - 1);
        do_load(16'h00F0, 4'h0, 4'hF, 1'b1);
        idle(40);

        do_load(16'h4321, 4'b0010, 4'b0101, 1'b0);
        idle(70);

        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) begin
                for (int j = 0; j < ND; j++)
                    rv[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                do_load(rv, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                        1'($urandom));
            end
            if (k % 300 == 0) begin
                wait_phase(FRAME - 1);
                do_load(16'($urandom), 4'($urandom), 4'hF, 1'b1);
            end
        end

        // Mid-slot reset: index 2, past the guard.
        begin
            int k;
            k = 0;
            while (!((n / RD) % ND == 2 && n % RD == 4) && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (k >= 200) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_mid_slot: index 2 slot not reached");
            end
        end
        #2 rst = 1'b1;
        #1 check("async_reset", {AN, seg, DP, frame_done}, INACTIVE);
        idle(2);
        check("reset_hold", {AN, seg, DP, frame_done}, INACTIVE);
        rst = 1'b0;
        idle(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
